// File: rtl/apc_stream_accum_ctrl.sv
// rtl/apc_stream_accum_ctrl.sv - windowed stochastic-stream accumulator around a shared external APC
// Optional: define APC_SUM_PIPE_EN to register the APC sum ahead of the accumulator (adds a DRAIN state).
module apc_stream_accum_ctrl #(
  parameter int STREAM_LEN = 256,
  parameter int CNT_W      = $clog2(STREAM_LEN),
  parameter int ACC_W      = 5 + $clog2(STREAM_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [30:0]      stream_in,
  input  logic             stream_valid,
  output logic             stream_ready,
  output logic [30:0]      apc_stream,
  input  logic [4:0]       apc_sum,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             accept;
  logic             last_beat;
  logic             add_en;
  logic [ACC_W-1:0] add_val;

  // abort wins over a presented beat, so the handshake itself is gated
  assign stream_ready = (state_q == S_RUN) && !abort;
  assign accept       = stream_ready && stream_valid;
  assign last_beat    = accept && (beat_cnt_q == CNT_W'(STREAM_LEN - 1));
  assign apc_stream   = (state_q == S_RUN) ? stream_in : '0;
  assign result       = result_q;
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign beat_cnt     = beat_cnt_q;

`ifdef APC_SUM_PIPE_EN
  logic [4:0] sum_q, sum_d;
  logic       acc_en_q, acc_en_d;

  always_comb begin
    sum_d    = abort ? 5'd0 : apc_sum;
    acc_en_d = accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q    <= 5'd0;
      acc_en_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      acc_en_q <= acc_en_d;
    end
  end

  assign add_en  = acc_en_q;
  assign add_val = {{(ACC_W-5){1'b0}}, sum_q};
`else
  assign add_en  = accept;
  assign add_val = {{(ACC_W-5){1'b0}}, apc_sum};
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    beat_cnt_d = beat_cnt_q;
    result_d   = result_q;

    if (add_en) begin
      acc_d = acc_q + add_val;
    end
    if (accept) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          acc_d      = '0;
          beat_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (last_beat) begin
`ifdef APC_SUM_PIPE_EN
          state_d  = S_DRAIN;
`else
          state_d  = S_DONE;
          result_d = acc_d;
`endif
        end
      end
`ifdef APC_SUM_PIPE_EN
      S_DRAIN: begin
        state_d  = S_DONE;
        result_d = acc_d;
      end
`endif
      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // result is deliberately left alone so the last completed window stays readable
    if (abort) begin
      state_d    = S_IDLE;
      acc_d      = '0;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      beat_cnt_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      beat_cnt_q <= beat_cnt_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_apc_stream_accum_ctrl.sv
// tb/tb_apc_stream_accum_ctrl.sv - directed bench for apc_stream_accum_ctrl with STREAM_LEN=4
module tb_apc_stream_accum_ctrl;

  localparam int LEN   = 4;
  localparam int CNT_W = 2;
  localparam int ACC_W = 7;
`ifdef APC_SUM_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [30:0]      stream_in;
  logic             stream_valid;
  logic             stream_ready;
  logic [30:0]      apc_stream;
  logic [4:0]       apc_sum;
  logic [ACC_W-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             busy;
  logic [CNT_W-1:0] beat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  apc_stream_accum_ctrl #(.STREAM_LEN(LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .stream_in(stream_in), .stream_valid(stream_valid), .stream_ready(stream_ready),
    .apc_stream(apc_stream), .apc_sum(apc_sum),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .beat_cnt(beat_cnt)
  );

  // behavioural stand-in for the external combinational APC
  assign apc_sum = 5'($countones(apc_stream));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] ones(input int n);
    logic [31:0] m;
    m = (32'h1 << n) - 32'h1;
    return m[30:0];
  endfunction

  // inputs change just after the falling edge; checks run 1 ns later
  task automatic step(input logic s, input logic a, input logic v, input logic [30:0] d,
                      input logic rr);
    @(negedge clk);
    start = s; abort = a; stream_valid = v; stream_in = d; result_ready = rr;
    #1;
  endtask

  task automatic do_start();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("start_idle_busy", 32'(busy), 0);
  endtask

  task automatic beat(input int n, input int exp_cnt);
    step(1'b0, 1'b0, 1'b1, ones(n), 1'b0);
    chk("run_ready", 32'(stream_ready), 1);
    chk("run_apc_stream", 32'(apc_stream), 32'(ones(n)));
    chk("run_beat_cnt", 32'(beat_cnt), 32'(exp_cnt));
  endtask

  task automatic wait_done(input int exp);
    for (int k = 1; k < LAT; k++) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      chk("drain_rv", 32'(result_valid), 0);
      chk("drain_ready", 32'(stream_ready), 0);
    end
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("done_rv", 32'(result_valid), 1);
    chk("done_result", 32'(result), 32'(exp));
    chk("done_ready", 32'(stream_ready), 0);
    chk("done_beat_cnt", 32'(beat_cnt), 0);
  endtask

  task automatic take(input int exp);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("take_rv", 32'(result_valid), 0);
    chk("take_busy", 32'(busy), 0);
    chk("take_result_held", 32'(result), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; stream_valid = 1'b0;
    stream_in = '0; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rv", 32'(result_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_beat_cnt", 32'(beat_cnt), 0);
    chk("rst_ready", 32'(stream_ready), 0);
    rst = 1'b0;

    // 1: four full beats
    do_start();
    for (int i = 0; i < LEN; i++) begin
      beat(31, i);
      chk("t1_busy", 32'(busy), 1);
    end
    wait_done(124);
    take(124);

    // 2: bubbles with live data must not accumulate
    do_start();
    beat(3, 0);
    beat(0, 1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, ones(31), 1'b0);
      chk("t2_bubble_cnt", 32'(beat_cnt), 2);
    end
    beat(17, 2);
    beat(5, 3);
    wait_done(25);
    take(25);

    // 3: result backpressure with ignored start pulses
    do_start();
    for (int i = 0; i < LEN; i++) beat(i + 1, i);
    wait_done(10);
    for (int i = 0; i < 5; i++) begin
      step(1'(i % 2), 1'b0, 1'b0, '0, 1'b0);
      chk("t3_hold_rv", 32'(result_valid), 1);
      chk("t3_hold_result", 32'(result), 10);
    end
    take(10);
    chk("t3_not_run", 32'(stream_ready), 0);

    // 4: abort alongside the third beat
    do_start();
    beat(2, 0);
    beat(2, 1);
    step(1'b0, 1'b1, 1'b1, ones(31), 1'b0);
    chk("t4_abort_ready", 32'(stream_ready), 0);
    step(1'b0, 1'b0, 1'b1, ones(31), 1'b0);
    chk("t4_idle_busy", 32'(busy), 0);
    chk("t4_idle_cnt", 32'(beat_cnt), 0);
    chk("t4_idle_rv", 32'(result_valid), 0);
    chk("t4_result_kept", 32'(result), 10);
    chk("t4_idle_apc", 32'(apc_stream), 0);
    stream_valid = 1'b0;
    do_start();
    for (int i = 0; i < LEN; i++) beat(1, i);
    wait_done(4);
    take(4);

    // 5: asynchronous reset mid-window
    do_start();
    beat(5, 0);
    beat(5, 1);
    step(1'b0, 1'b0, 1'b1, ones(5), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_cnt", 32'(beat_cnt), 0);
    chk("t5_rv", 32'(result_valid), 0);
    chk("t5_result", 32'(result), 0);
    chk("t5_ready", 32'(stream_ready), 0);
    chk("t5_apc", 32'(apc_stream), 0);
    @(negedge clk);
    rst = 1'b0; stream_valid = 1'b0;
    do_start();
    for (int i = 0; i < LEN; i++) beat(7, i);
    wait_done(28);
    take(28);

    // 6: start with abort stays idle
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ready", 32'(stream_ready), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apc_stream_accum_ctrl.md
Name: apc_stream_accum_ctrl

Overview:
- Sequences one shared 31-input approximate parallel counter (APC) over a fixed-length stochastic bitstream window and integrates the per-cycle 5-bit popcounts into a binary result.
- Sits between a stochastic PE output lane and the binary writeback path of the SC CGRA.
- Owns start/abort, the beat handshake, window counting and result hand-off.
- The parallel counter is external and purely combinational. This block drives its input vector and consumes its sum.

Parameters:
STREAM_LEN, 256, number of accepted 31-bit beats per window (>=2).
CNT_W, $clog2(STREAM_LEN), beat counter width.
ACC_W, 5+$clog2(STREAM_LEN), accumulator/result width. 31*STREAM_LEN always fits, so no overflow is possible.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a window. Honoured only in IDLE.
abort  input  1  synchronous abort. Returns the block to IDLE from any state.
stream_in  input  31  stochastic beat, one bit per lane.
stream_valid  input  1  stream_in holds a valid beat.
stream_ready  output  1  block accepts a beat this cycle.
apc_stream  output  31  vector driven into the external APC.
apc_sum  input  5  popcount returned by the APC, combinational from apc_stream.
result  output  ACC_W  accumulated count of the window.
result_valid  output  1  result holds a completed window.
result_ready  input  1  consumer takes result.
busy  output  1  high in any state other than IDLE.
beat_cnt  output  CNT_W  number of beats accepted so far in the current window.

Behaviour:
- Reset (async, rst=1): state=IDLE; acc=0; beat_cnt=0; result=0; result_valid=0; stream_ready=0; busy=0. apc_stream is 0 whenever not in RUN.
- States: IDLE, RUN, DRAIN (only with the option macro), DONE.
- IDLE:
  - start=1 and abort=0 -> RUN next cycle.
  - acc and beat_cnt clear to 0 on that transition.
  - result_valid stays 0.
- RUN:
  - stream_ready=1.
  - apc_stream = stream_in combinationally.
  - A beat is accepted when stream_valid && stream_ready.
  - On an accepted beat: acc <= acc + apc_sum (zero-extended to ACC_W) and beat_cnt <= beat_cnt+1.
  - stream_valid=0 is a bubble: no accumulation, no count.
  - Accepting the beat with beat_cnt==STREAM_LEN-1 moves to DONE next cycle, or to DRAIN with the option. beat_cnt then wraps to 0.
  - start is ignored while in RUN.
- DONE:
  - result=acc, held stable.
  - result_valid=1.
  - stream_ready=0.
  - result_valid && result_ready -> IDLE next cycle, result_valid deasserts.
  - result keeps its last value until the next window completes.
  - start is ignored in DONE. Back-to-back windows need one IDLE cycle.
- abort:
  - Has priority over start, beats and result_ready in the same cycle.
  - Next state is IDLE with acc=0, beat_cnt=0, result_valid=0.
  - A beat presented in the abort cycle is not accepted: stream_ready is forced low when abort=1.
  - result is not cleared by abort.
- Latency:
  - Result available 1 cycle after the last accepted beat, or 2 cycles with the option.
  - Minimum window duration is STREAM_LEN+1 cycles from the first RUN cycle.
- rst asserted mid-window discards all state immediately. No partial result is ever flagged valid.

Optional Feature:
APC_SUM_PIPE_EN
- Defined:
  - apc_sum and the accept strobe are registered (sum_q, acc_en_q), and acc adds sum_q when acc_en_q=1.
  - This breaks the APC-to-adder timing path.
  - After the last beat the FSM enters DRAIN for exactly one cycle (stream_ready=0, pending sum added), then DONE.
  - abort in DRAIN also clears sum_q and acc_en_q.
- Not defined:
  - Accumulation is same-cycle, DRAIN is never entered, and it adds no logic.

Test Plan:
1. STREAM_LEN=4; start; 4 beats of 31'h7FFF_FFFF with apc_sum=31, valid every cycle -> result=124, result_valid 1 cycle after the 4th beat (2 cycles with APC_SUM_PIPE_EN), busy high throughout.
2. STREAM_LEN=4; beats with sums 3,0,17,5, and valid low for 2 cycles between beat 2 and beat 3 -> result=25, beat_cnt sequence 0,1,2,2,2,3,0, no accumulation during bubbles.
3. Result backpressure: result_ready held 0 for 5 cycles after DONE -> result_valid and result stable; start pulses during DONE ignored; result_ready=1 -> IDLE next cycle.
4. abort asserted together with the 3rd valid beat -> stream_ready=0 that cycle, IDLE next, acc=0, beat_cnt=0, result_valid never asserted; a following window of 4x sum=1 gives result=4.
5. rst pulsed asynchronously (mid-cycle) during RUN after 2 beats -> all outputs at reset values immediately; a new start gives a correct fresh window.
6. start and abort high together in IDLE -> stays IDLE, busy=0.
